bytes_to_bridge: RTL and testbench

Read-side counterpart of the loader's word-to-byte write path. Accepts a 32-bit bridge read request and issues four consecutive byte reads to a byte-wide memory. Assembles the returned bytes big-endian into one 32-bit word and presents it on the bridge with a one-cycle valid pulse. Sits between the APF bridge read port and any byte-addressed memory the loader exposes.

---
 rtl/loader_pkg.sv | 7 +
 rtl/strobe_delay.sv | 15 +
 rtl/bytes_to_bridge.sv | 72 +++++++
 tb/tb_bytes_to_bridge.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and widths for the loader bridge paths
package loader_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} bytes_to_bridge_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int BRIDGE_W = 32;
  localparam int MEM_DATA_W = 8;
endpackage

// File: rtl/strobe_delay.sv
// strobe_delay: STAGES-deep 1-bit shift register with synchronous clear
module strobe_delay #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;
  // shift the strobe one stage per cycle; clear discards anything in flight
  always_ff @(posedge clk)
    sr <= clear ? '0 : STAGES'({sr, d});
  assign q = sr[STAGES-1];
endmodule

// File: rtl/bytes_to_bridge.sv
// bytes_to_bridge: four byte reads assembled big-endian into one bridge word
module bytes_to_bridge
  import loader_pkg::*;
#(
  parameter logic [BRIDGE_W-1:0] valid_bits = '1,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BRIDGE_W-1:0]   bridge_addr,
  input  logic                  bridge_rd,
  output logic [BRIDGE_W-1:0]   bridge_rd_data,
  output logic                  bridge_rd_valid,
  output logic [BRIDGE_W-1:0]   mem_address,
  output logic                  mem_rd,
  input  logic [MEM_DATA_W-1:0] mem_rd_data
);
  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
  bytes_to_bridge_state_t state;
  logic [1:0] issued;
  logic [1:0] captured;
  logic [BRIDGE_W-1:0] word;
  logic ret;
  logic in_range;
  assign in_range = (bridge_addr & ~valid_bits) == '0;
  assign bridge_rd_valid = state == DONE;
  strobe_delay #(.STAGES(READ_LATENCY)) u_delay (
    .clk(clk),
    .clear(reset),
    .d(mem_rd),
    .q(ret)
  );
  // request sequencing: accept in IDLE, issue four byte reads, wait for the last return
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      issued <= '0;
      mem_rd <= 1'b0;
      mem_address <= '0;
      bridge_rd_data <= '0;
    end else
      case (state)
        IDLE: if (bridge_rd) begin
          state <= in_range ? ISSUE : DONE;
          mem_rd <= in_range;
          issued <= '0;
          if (in_range) mem_address <= bridge_addr;
          else bridge_rd_data <= '0;
        end
        ISSUE: begin
          issued <= issued + 2'd1;
          if (issued == LAST) begin
            mem_rd <= 1'b0;
            state <= DRAIN;
          end else mem_address <= mem_address + 1'b1;
        end
        DRAIN: if (ret && captured == LAST) begin
          state <= DONE;
          bridge_rd_data <= {word[BRIDGE_W-MEM_DATA_W-1:0], mem_rd_data};
        end
        default: state <= IDLE;
      endcase
  // shift each returned byte in as its delayed strobe arrives, first byte ends up on top
  always_ff @(posedge clk)
    if (reset) begin
      word <= '0;
      captured <= '0;
    end else if (ret) begin
      word <= {word[BRIDGE_W-MEM_DATA_W-1:0], mem_rd_data};
      captured <= captured + 2'd1;
    end
endmodule

// File: tb/tb_bytes_to_bridge.sv
// tb_bytes_to_bridge: randomized check of three latency/mask configurations against a transaction model
module tb_bytes_to_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst, br_rd, rd_valid, mem_rd;
  logic [2:0][31:0] br_addr, rd_data, mem_addr;
  logic [2:0][7:0] mem_data;
  logic [7:0] junk;
  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int d);
    return d == 0 ? 1 : d == 1 ? 3 : 2;
  endfunction

  function automatic logic [31:0] mask_of(input int d);
    return d == 1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5 ^ {a[1:0], 6'd0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) junk <= 8'($urandom);

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int L = lat_of(g);
    logic [31:0] aq [8];
    logic [7:0] vq;
    bytes_to_bridge #(.valid_bits(mask_of(g)), .READ_LATENCY(L)) dut (
      .clk(clk),
      .reset(rst[g]),
      .bridge_addr(br_addr[g]),
      .bridge_rd(br_rd[g]),
      .bridge_rd_data(rd_data[g]),
      .bridge_rd_valid(rd_valid[g]),
      .mem_address(mem_addr[g]),
      .mem_rd(mem_rd[g]),
      .mem_rd_data(mem_data[g])
    );
    always @(posedge clk) begin
      vq <= {vq[6:0], mem_rd[g]};
      aq[0] <= mem_addr[g];
      for (int i = 1; i < 8; i++) aq[i] <= aq[i-1];
    end
    assign mem_data[g] = vq[L-1] ? mem_byte(aq[L-1]) : junk;
  end

  task automatic run_read(input int d, input logic [31:0] a, input int rd2_at, input logic [31:0] a2, input int rst_at);
    int lat;
    bit inr;
    logic [31:0] seen[$];
    int first_rd;
    int n_valid;
    int v_cycle;
    int n_exp;
    logic [31:0] v_data;
    logic [31:0] exp_word;
    lat = lat_of(d);
    inr = (a & ~mask_of(d)) == 32'h0;
    first_rd = 0;
    n_valid = 0;
    v_cycle = 0;
    v_data = 32'h0;
    exp_word = inr ? {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)} : 32'h0;
    n_exp = rst_at > 0 ? (rst_at < 4 ? rst_at : 4) : (inr ? 4 : 0);
    @(negedge clk);
    br_addr[d] = a;
    br_rd[d] = 1'b1;
    for (int c = 1; c <= 8 + lat; c++) begin
      @(negedge clk);
      br_rd[d] = 1'b0;
      rst[d] = 1'b0;
      if (mem_rd[d]) begin
        if (seen.size() == 0) first_rd = c;
        seen.push_back(mem_addr[d]);
      end
      if (rd_valid[d]) begin
        n_valid++;
        v_cycle = c;
        v_data = rd_data[d];
      end
      if (c == rd2_at) begin
        br_addr[d] = a2;
        br_rd[d] = 1'b1;
      end
      if (c == rst_at) rst[d] = 1'b1;
    end
    chk("rd_count", 32'(seen.size()), 32'(n_exp));
    for (int i = 0; i < seen.size() && i < n_exp; i++) chk("rd_addr", seen[i], a + 32'(i));
    if (n_exp > 0) chk("rd_first_cycle", 32'(first_rd), 32'd1);
    chk("valid_count", 32'(n_valid), rst_at > 0 ? 32'd0 : 32'd1);
    if (rst_at == 0) begin
      chk("valid_cycle", 32'(v_cycle), inr ? 32'(5 + lat) : 32'd1);
      chk("rd_data", v_data, exp_word);
      chk("data_held", rd_data[d], exp_word);
    end else chk("data_after_reset", rd_data[d], 32'h0);
  endtask

  initial begin
    int d;
    int lat;
    int rd2;
    int rs;
    logic [31:0] a;
    bit inr;
    rst = '1;
    br_rd = '0;
    br_addr = '0;
    repeat (3) @(negedge clk);
    rst = '0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_data", rd_data[k], 32'h0);
      chk("rst_valid", 32'(rd_valid[k]), 32'h0);
      chk("rst_mem_rd", 32'(mem_rd[k]), 32'h0);
      chk("rst_mem_addr", mem_addr[k], 32'h0);
    end
    run_read(0, 32'h0000_0100, 0, 32'h0, 0);
    run_read(1, 32'h0000_0100, 0, 32'h0, 0);
    run_read(1, 32'h0001_0000, 0, 32'h0, 0);
    run_read(0, 32'h0000_0100, 2, 32'h0000_0200, 0);
    run_read(0, 32'hFFFF_FFFE, 0, 32'h0, 0);
    run_read(2, 32'h0000_0100, 0, 32'h0, 3);
    run_read(2, 32'h0000_0100, 0, 32'h0, 0);
    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 2));
      lat = lat_of(d);
      a = $urandom;
      if (d == 1 && $urandom_range(0, 1) == 1) a[31:16] = 16'h0;
      inr = (a & ~mask_of(d)) == 32'h0;
      rs = inr && $urandom_range(0, 4) == 0 ? int'($urandom_range(1, 4 + lat)) : 0;
      rd2 = inr && rs == 0 && $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 5 + lat)) : 0;
      run_read(d, a, rd2, $urandom, rs);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
